// File: rtl/tag_compare_unit.sv
// Tag compare stage: pops one tag-FIFO entry, waits for its metadata response,
// and produces a registered hit/miss/evict decision plus hit/miss statistics.
module tag_compare_unit #(
    parameter int unsigned TAG_WIDTH   = 38,
    parameter int unsigned INDEX_WIDTH = 20,
    parameter int unsigned META_WIDTH  = 40
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tag_fifo_empty_i,
    output logic                             tag_fifo_rden_o,
    input  logic [74:0]                      tag_fifo_data_i,
    input  logic [15:0]                      rid_i,
    input  logic [META_WIDTH-1:0]            rdata_i,
    input  logic                             rvalid_i,
    output logic                             rready_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic [15:0]                      res_id_o,
    output logic                             res_write_o,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] res_addr_o,
    output logic                             res_hit_o,
    output logic                             res_evict_o,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] res_victim_addr_o,
    output logic                             id_err_o,
    output logic [31:0]                      hit_cnt_o,
    output logic [31:0]                      miss_cnt_o
);

    localparam int unsigned ADDR_W = TAG_WIDTH + INDEX_WIDTH;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic              is_write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_META, RESULT} state_e;

    state_e            state_q, state_d;
    entry_t            entry_q, entry_d;
    logic              res_valid_q, res_valid_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_write_q, res_write_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic              res_hit_q, res_hit_d;
    logic              res_evict_q, res_evict_d;
    logic [ADDR_W-1:0] res_victim_q, res_victim_d;
    logic              id_err_q, id_err_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              rden_c, rready_c;

    logic                   meta_valid, meta_dirty, hit_c;
    logic [TAG_WIDTH-1:0]   stored_tag, req_tag;
    logic [INDEX_WIDTH-1:0] req_index;

    assign meta_valid = rdata_i[META_WIDTH-1];
    assign meta_dirty = rdata_i[META_WIDTH-2];
    assign stored_tag = rdata_i[TAG_WIDTH-1:0];
    assign req_tag    = entry_q.addr[ADDR_W-1:INDEX_WIDTH];
    assign req_index  = entry_q.addr[INDEX_WIDTH-1:0];
    assign hit_c      = meta_valid && (stored_tag == req_tag);

    // Next-state, handshakes and decision capture
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_write_d  = res_write_q;
        res_addr_d   = res_addr_q;
        res_hit_d    = res_hit_q;
        res_evict_d  = res_evict_q;
        res_victim_d = res_victim_q;
        id_err_d     = id_err_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        rden_c       = 1'b0;
        rready_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!tag_fifo_empty_i) begin
                    rden_c  = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                entry_d = tag_fifo_data_i;
                state_d = WAIT_META;
            end
            WAIT_META: begin
                rready_c = 1'b1;
                if (rvalid_i) begin
                    res_valid_d  = 1'b1;
                    res_id_d     = entry_q.id;
                    res_write_d  = entry_q.is_write;
                    res_addr_d   = entry_q.addr;
                    res_hit_d    = hit_c;
                    res_evict_d  = meta_valid && meta_dirty && !hit_c;
                    res_victim_d = {stored_tag, req_index};
                    if (rid_i != entry_q.id) begin
                        id_err_d = 1'b1;
                    end
                    if (hit_c) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    // Refill in the handshake cycle keeps the 3-cycle cadence
                    if (!tag_fifo_empty_i) begin
                        rden_c  = 1'b1;
                        state_d = CAPTURE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_write_q  <= 1'b0;
            res_addr_q   <= '0;
            res_hit_q    <= 1'b0;
            res_evict_q  <= 1'b0;
            res_victim_q <= '0;
            id_err_q     <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_write_q  <= res_write_d;
            res_addr_q   <= res_addr_d;
            res_hit_q    <= res_hit_d;
            res_evict_q  <= res_evict_d;
            res_victim_q <= res_victim_d;
            id_err_q     <= id_err_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Pop and R-ready are suppressed in the reset cycle
    assign tag_fifo_rden_o   = rden_c && !rst;
    assign rready_o          = rready_c && !rst;
    assign res_valid_o       = res_valid_q;
    assign res_id_o          = res_id_q;
    assign res_write_o       = res_write_q;
    assign res_addr_o        = res_addr_q;
    assign res_hit_o         = res_hit_q;
    assign res_evict_o       = res_evict_q;
    assign res_victim_addr_o = res_victim_q;
    assign id_err_o          = id_err_q;
    assign hit_cnt_o         = hit_cnt_q;
    assign miss_cnt_o        = miss_cnt_q;

endmodule

// File: tb/tb_tag_compare_unit.sv
// Scoreboard bench for tag_compare_unit: FIFO/metadata models drive inputs,
// a monitor pops expected decisions on each output handshake.
module tb_tag_compare_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        tag_fifo_empty_i;
    logic        tag_fifo_rden_o;
    logic [74:0] tag_fifo_data_i;
    logic [15:0] rid_i;
    logic [39:0] rdata_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_id_o;
    logic        res_write_o;
    logic [57:0] res_addr_o;
    logic        res_hit_o;
    logic        res_evict_o;
    logic [57:0] res_victim_addr_o;
    logic        id_err_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    tag_compare_unit dut (
        .clk               (clk),
        .rst               (rst),
        .tag_fifo_empty_i  (tag_fifo_empty_i),
        .tag_fifo_rden_o   (tag_fifo_rden_o),
        .tag_fifo_data_i   (tag_fifo_data_i),
        .rid_i             (rid_i),
        .rdata_i           (rdata_i),
        .rvalid_i          (rvalid_i),
        .rready_o          (rready_o),
        .res_valid_o       (res_valid_o),
        .res_ready_i       (res_ready_i),
        .res_id_o          (res_id_o),
        .res_write_o       (res_write_o),
        .res_addr_o        (res_addr_o),
        .res_hit_o         (res_hit_o),
        .res_evict_o       (res_evict_o),
        .res_victim_addr_o (res_victim_addr_o),
        .id_err_o          (id_err_o),
        .hit_cnt_o         (hit_cnt_o),
        .miss_cnt_o        (miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rid;
        logic [39:0] rdata;
    } meta_t;

    typedef struct {
        logic [15:0] id;
        logic        wr;
        logic [57:0] addr;
        logic        hit;
        logic        evict;
        logic [57:0] victim;
        logic [31:0] hc;
        logic [31:0] mc;
        logic        ierr;
    } exp_t;

    logic [74:0] fifo_q[$];
    meta_t       meta_q[$];
    exp_t        sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] id, input logic [57:0] addr,
                         input logic [15:0] rid, input logic [39:0] rdata,
                         input logic e_hit, input logic e_evict, input logic [57:0] e_victim,
                         input logic [31:0] e_hc, input logic [31:0] e_mc, input logic e_ierr);
        meta_t m;
        exp_t  e;
        m.rid = rid;
        m.rdata = rdata;
        e.id = id; e.wr = wr; e.addr = addr; e.hit = e_hit; e.evict = e_evict;
        e.victim = e_victim; e.hc = e_hc; e.mc = e_mc; e.ierr = e_ierr;
        fifo_q.push_back({wr, id, addr});
        meta_q.push_back(m);
        sb.push_back(e);
    endtask

    // FIFO and metadata-channel models: update after posedge, sample handshakes mid-low phase
    initial begin
        logic pop_f;
        logic r_hs;
        pop_f = 1'b0;
        r_hs  = 1'b0;
        tag_fifo_empty_i = 1'b1;
        tag_fifo_data_i  = '0;
        rvalid_i = 1'b0;
        rid_i    = '0;
        rdata_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (pop_f && fifo_q.size() > 0) tag_fifo_data_i = fifo_q.pop_front();
            if (r_hs && meta_q.size() > 0) meta_q.delete(0);
            tag_fifo_empty_i = (fifo_q.size() == 0);
            if (meta_q.size() > 0) begin
                rvalid_i = 1'b1;
                rid_i    = meta_q[0].rid;
                rdata_i  = meta_q[0].rdata;
            end else begin
                rvalid_i = 1'b0;
            end
            @(negedge clk); #2;
            pop_f = tag_fifo_rden_o;
            r_hs  = rvalid_i && rready_o;
            if (pop_f) pop_cyc = cyc;
        end
    end

    // Monitor: latency on each new decision, full compare on each output handshake
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (res_valid_o && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - pop_cyc), 64'd3);
            end
            prev_v = res_valid_o;
            if (res_valid_o && res_ready_i && sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_id",     64'(res_id_o),          64'(e.id));
                chk("res_write",  64'(res_write_o),       64'(e.wr));
                chk("res_addr",   64'(res_addr_o),        64'(e.addr));
                chk("res_hit",    64'(res_hit_o),         64'(e.hit));
                chk("res_evict",  64'(res_evict_o),       64'(e.evict));
                chk("res_victim", 64'(res_victim_addr_o), 64'(e.victim));
                chk("hit_cnt",    64'(hit_cnt_o),         64'(e.hc));
                chk("miss_cnt",   64'(miss_cnt_o),        64'(e.mc));
                chk("id_err",     64'(id_err_o),          64'(e.ierr));
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        res_ready_i = 1'b1;
        // Read hit, queued while reset is held with FIFO non-empty and rvalid high
        issue(1'b0, 16'd3, 58'h500012, 16'd3, {1'b1, 1'b0, 38'h5},
              1'b1, 1'b0, 58'h500012, 32'd1, 32'd0, 1'b0);
        repeat (2) begin
            @(negedge clk); #3;
            chk("rst_rden",   64'(tag_fifo_rden_o), 64'd0);
            chk("rst_rready", 64'(rready_o),        64'd0);
            chk("rst_valid",  64'(res_valid_o),     64'd0);
            chk("rst_hitcnt", 64'(hit_cnt_o),       64'd0);
            chk("rst_miscnt", 64'(miss_cnt_o),      64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_drain("read_hit");

        // Dirty miss on a write
        issue(1'b1, 16'd7, 58'h500012, 16'd7, {1'b1, 1'b1, 38'h7},
              1'b0, 1'b1, 58'h700012, 32'd1, 32'd1, 1'b0);
        wait_drain("dirty_miss");

        // Invalid line with matching tag: miss, no evict
        issue(1'b0, 16'd8, 58'h500012, 16'd8, {1'b0, 1'b1, 38'h5},
              1'b0, 1'b0, 58'h500012, 32'd1, 32'd2, 1'b0);
        wait_drain("invalid_line");

        // Backpressure with two entries queued
        @(negedge clk);
        res_ready_i = 1'b0;
        issue(1'b0, 16'h10, 58'h2AABCDE, 16'h10, {1'b1, 1'b1, 38'h2A},
              1'b1, 1'b0, 58'h2AABCDE, 32'd2, 32'd2, 1'b0);
        issue(1'b0, 16'h11, 58'h3F00001, 16'h11, {1'b1, 1'b0, 38'h10},
              1'b0, 1'b0, 58'h1000001, 32'd2, 32'd3, 1'b0);
        n = 0;
        while (!res_valid_o && n < 50) begin
            @(negedge clk); #3;
            n++;
        end
        chk("bp_valid_seen", 64'(res_valid_o), 64'd1);
        repeat (5) begin
            @(negedge clk); #3;
            chk("bp_no_pop",  64'(tag_fifo_rden_o), 64'd0);
            chk("bp_rready",  64'(rready_o),        64'd0);
            chk("bp_valid",   64'(res_valid_o),     64'd1);
            chk("bp_id_hold", 64'(res_id_o),        64'h10);
            chk("bp_addr",    64'(res_addr_o),      64'h2AABCDE);
        end
        @(negedge clk);
        res_ready_i = 1'b1;
        wait_drain("backpressure");

        // Wide tag, all-ones stored tag: dirty miss with full-width victim
        issue(1'b1, 16'hFFFF, 58'h2000000001FFFFF, 16'hFFFF, {1'b1, 1'b1, 38'h3F_FFFF_FFFF},
              1'b0, 1'b1, 58'h3FF_FFFF_FFFF_FFFF, 32'd2, 32'd4, 1'b0);
        wait_drain("wide_tag");

        // id mismatch sets a sticky error; the decision keeps the entry id
        issue(1'b0, 16'd4, 58'h500012, 16'd9, {1'b1, 1'b0, 38'h5},
              1'b1, 1'b0, 58'h500012, 32'd3, 32'd4, 1'b1);
        issue(1'b0, 16'd5, 58'h500012, 16'd5, {1'b1, 1'b0, 38'h5},
              1'b1, 1'b0, 58'h500012, 32'd4, 32'd4, 1'b1);
        wait_drain("id_mismatch");

        // Preload the hit counter to its maximum, next hit wraps to zero
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        #3;
        chk("preload", 64'(hit_cnt_o), 64'hFFFF_FFFF);
        issue(1'b0, 16'd6, 58'h500012, 16'd6, {1'b1, 1'b0, 38'h5},
              1'b1, 1'b0, 58'h500012, 32'd0, 32'd4, 1'b1);
        wait_drain("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_compare_unit.md
Name: tag_compare_unit

Overview:
- Consumer end of the tag FIFO that the index-extraction stage fills.
- Pops one request entry (id, block address, read/write flag), waits for the matching metadata read response from the DRAM-cache metadata array, and compares the stored tag against the request tag.
- Emits one hit/miss/evict decision per entry downstream and keeps hit/miss statistics counters.

Parameters:
- TAG_WIDTH, 38, tag bits; block address = {tag, index}.
- INDEX_WIDTH, 20, set index bits (direct-mapped). TAG_WIDTH+INDEX_WIDTH must equal 58.
- META_WIDTH, 40, metadata word {valid, dirty, tag}; must equal TAG_WIDTH+2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tag_fifo_empty_i  in  1  tag FIFO empty
- tag_fifo_rden_o  out  1  tag FIFO pop; data valid on tag_fifo_data_i one cycle later
- tag_fifo_data_i  in  75  entry: [74]=is_write, [73:58]=id, [57:0]=block address (addr[63:6])
- rid_i  in  16  metadata response id
- rdata_i  in  META_WIDTH  [META_WIDTH-1]=valid, [META_WIDTH-2]=dirty, [TAG_WIDTH-1:0]=stored tag
- rvalid_i  in  1  metadata response valid
- rready_o  out  1  metadata response ready
- res_valid_o  out  1  decision valid
- res_ready_i  in  1  downstream ready
- res_id_o  out  16  request id
- res_write_o  out  1  request was a write
- res_addr_o  out  58  request block address
- res_hit_o  out  1  tag match with valid line
- res_evict_o  out  1  miss on valid dirty line (writeback required)
- res_victim_addr_o  out  58  {stored tag, index}
- id_err_o  out  1  sticky: rid_i differed from entry id
- hit_cnt_o  out  32  hits counted
- miss_cnt_o  out  32  misses counted

Behaviour:
- Decided: one clock (clk); reset rst is synchronous and active-high.
- Reset: FSM=IDLE; tag_fifo_rden_o, rready_o, res_valid_o, id_err_o = 0; all res_* data, counters and entry register = 0. Reset mid-operation discards any popped entry and any pending decision; no FIFO pop and no R handshake in the reset cycle.
- FSM:
  - IDLE: tag_fifo_rden_o = !tag_fifo_empty_i (combinational); if popping -> CAPTURE.
  - CAPTURE: latch tag_fifo_data_i into entry register -> WAIT_META.
  - WAIT_META: rready_o=1. On rvalid_i: register decision into res_*, update counters, set id_err_o if rid_i != entry id; -> RESULT. rready_o is 0 in every other state; responses arriving early are backpressured.
  - RESULT: res_valid_o=1, res_* stable until res_valid_o && res_ready_i.
    - On handshake with !tag_fifo_empty_i: assert tag_fifo_rden_o in the same cycle -> CAPTURE.
    - On handshake with FIFO empty: -> IDLE.
    - Without handshake: hold.
- Decision (registered on R handshake):
  - req_tag = addr[57:INDEX_WIDTH]; index = addr[INDEX_WIDTH-1:0].
  - hit = valid && (stored tag == req_tag).
  - evict = valid && dirty && !hit.
  - victim_addr = {stored tag, index}; this is driven even on a hit.
- Counters: +1 hit_cnt_o on hit, +1 miss_cnt_o on miss, both at R handshake. Each wraps 0xFFFF_FFFF -> 0.
- Latency: FIFO non-empty in IDLE -> res_valid_o at earliest 3 cycles after the pop cycle when rvalid_i is already high. Back-to-back throughput is one decision per 3 cycles.
- id mismatch: decision still produced using the entry's id; id_err_o stays 1 until rst.
- FIFO never popped while a decision is pending without handshake; at most one entry in flight.

Test Plan:
- Reset: hold rst 2 cycles with FIFO non-empty and rvalid_i=1 -> tag_fifo_rden_o=0, rready_o=0, res_valid_o=0, counters 0.
- Read hit: entry {0, id=3, addr=0x500012}, rdata={1,0,tag 0x5}, rid=3 -> 3 cycles after pop: res_valid_o=1, res_hit_o=1, res_evict_o=0, res_id_o=3, hit_cnt_o=1.
- Dirty miss: entry {1, id=7, addr=0x500012}, rdata={1,1,tag 0x7} -> res_hit_o=0, res_evict_o=1, res_victim_addr_o=0x700012, res_write_o=1, miss_cnt_o=1.
- Invalid line: rdata={0,1,tag 0x5} with matching tag -> hit=0, evict=0, miss counted.
- Backpressure and back-to-back:
  - Two entries queued, res_ready_i=0 for 5 cycles -> res_* stable, no second pop.
  - Release res_ready_i -> pop in the handshake cycle, second decision valid 3 cycles later.
- id mismatch and wrap:
  - rid=9 vs entry id=4 -> decision res_id_o=4, id_err_o=1 sticky across later requests.
  - Force hit_cnt_o to 0xFFFFFFFF via 2^32 hits, or a test-only preload -> next hit gives 0.
